// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
// Optional macro: FIFO_UART_TX_PARITY_EN adds the PARITY state.
package fifo_uart_pkg;

    localparam int   DATA_BITS  = 8;
    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef FIFO_UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of
// each bit period. A synchronous clear holds the count at zero.
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count;

    // Free-running wrap counter, parked at zero while cleared.
    always_ff @(posedge clock) begin
        if (!reset_n || clear) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops bytes from an upstream FIFO and sends
// START, 8 data bits LSB first, optional even parity, and STOP_BITS stops.
// Optional macro: FIFO_UART_TX_PARITY_EN inserts a parity bit after DATA.
//
// Handshake: fifo_read_enable is a one-cycle pop, asserted only in IDLE when
// tx_enable is high and fifo_empty is low; fifo_data is captured on the same
// rising edge and the FIFO is expected to advance its head on that edge.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       tx_enable,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_read_enable,
    output logic       serial_out,
    output logic       busy,
    output logic       byte_done
);

    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

    state_t                 state;
    logic [DATA_BITS-1:0]   shift_reg;
    logic [3:0]             bit_cnt;
    logic                   tick;
    logic                   clear;
`ifdef FIFO_UART_TX_PARITY_EN
    logic                   parity_bit;
`endif

    // The bit timer is held at zero in IDLE so START always gets a full period.
    assign clear = (state == IDLE);

    baud_tick_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (clear),
        .tick    (tick)
    );

    // Pop is gated by reset_n so no byte is lost while reset is held.
    assign fifo_read_enable = reset_n & tx_enable & ~fifo_empty & (state == IDLE);
    assign byte_done        = (state == STOP) & tick & (bit_cnt == LAST_STOP);

    // Frame sequencer; serial_out is loaded with the level of the state being entered.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= IDLE;
            serial_out <= IDLE_LEVEL;
            busy       <= 1'b0;
            shift_reg  <= '0;
            bit_cnt    <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    serial_out <= IDLE_LEVEL;
                    if (fifo_read_enable) begin
                        shift_reg  <= fifo_data;
                        bit_cnt    <= '0;
                        busy       <= 1'b1;
                        serial_out <= 1'b0;
                        state      <= START;
`ifdef FIFO_UART_TX_PARITY_EN
                        parity_bit <= ^fifo_data;
`endif
                    end
                end
                START: begin
                    if (tick) begin
                        serial_out <= shift_reg[0];
                        state      <= DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_cnt == LAST_DATA) begin
                            bit_cnt <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
                            serial_out <= parity_bit;
                            state      <= PARITY;
`else
                            serial_out <= IDLE_LEVEL;
                            state      <= STOP;
`endif
                        end else begin
                            bit_cnt    <= bit_cnt + 1'b1;
                            shift_reg  <= shift_reg >> 1;
                            serial_out <= shift_reg[1];
                        end
                    end
                end
`ifdef FIFO_UART_TX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        serial_out <= IDLE_LEVEL;
                        state      <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        if (bit_cnt == LAST_STOP) begin
                            bit_cnt <= '0;
                            busy    <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    serial_out <= IDLE_LEVEL;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: two instances (1 and 2 stop bits) at
// CLKS_PER_BIT=4, each fed by a small array-backed FIFO model.
// Honours FIFO_UART_TX_PARITY_EN when the bundle is built with it.
module tb_fifo_uart_tx;

    localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic       tx_en0, tx_en1;
    logic       fifo_empty0, fifo_empty1;
    logic [7:0] fifo_data0, fifo_data1;
    logic       rd_en0, rd_en1;
    logic       serial0, serial1;
    logic       busy0, busy1;
    logic       done0, done1;

    logic [7:0] mem0 [16];
    logic [7:0] mem1 [16];
    logic [3:0] wr0 = 4'd0;
    logic [3:0] wr1 = 4'd0;
    logic [3:0] rdi0 = 4'd0;
    logic [3:0] rdi1 = 4'd0;
    int         cyc = 0;
    int         pops0 = 0;
    int         pops1 = 0;
    int         pop_cyc0 = 0;

    int         tests_run = 0;
    int         tests_failed = 0;

    // ---- clock / reset ----
    always #5 clk = ~clk;

    // ---- DUTs ----
    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut0 (
        .clock            (clk),
        .reset_n          (reset_n),
        .tx_enable        (tx_en0),
        .fifo_empty       (fifo_empty0),
        .fifo_data        (fifo_data0),
        .fifo_read_enable (rd_en0),
        .serial_out       (serial0),
        .busy             (busy0),
        .byte_done        (done0)
    );

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut1 (
        .clock            (clk),
        .reset_n          (reset_n),
        .tx_enable        (tx_en1),
        .fifo_empty       (fifo_empty1),
        .fifo_data        (fifo_data1),
        .fifo_read_enable (rd_en1),
        .serial_out       (serial1),
        .busy             (busy1),
        .byte_done        (done1)
    );

    // ---- FIFO models ----
    assign fifo_empty0 = (wr0 == rdi0);
    assign fifo_empty1 = (wr1 == rdi1);
    assign fifo_data0  = mem0[rdi0];
    assign fifo_data1  = mem1[rdi1];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_en0) begin
            rdi0     <= rdi0 + 4'd1;
            pops0    <= pops0 + 1;
            pop_cyc0 <= cyc;
        end
        if (rd_en1) begin
            rdi1  <= rdi1 + 4'd1;
            pops1 <= pops1 + 1;
        end
    end

    // ---- driver tasks ----
    task automatic push0(input logic [7:0] b);
        mem0[wr0] = b;
        wr0 = wr0 + 4'd1;
    endtask

    task automatic push1(input logic [7:0] b);
        mem1[wr1] = b;
        wr1 = wr1 + 4'd1;
    endtask

    // ---- checking ----
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int frame_len(input int stop);
        return CPB * (1 + 8 + PBITS + stop);
    endfunction

    // Expected line level in frame cycle c (1-based).
    function automatic logic exp_level(input logic [7:0] d, input int c);
        int b;
        b = (c - 1) / CPB;
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
`ifdef FIFO_UART_TX_PARITY_EN
        if (b == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    task automatic sample(input int sel, output logic so, output logic bz,
                          output logic bd, output logic rd);
        so = (sel != 0) ? serial1 : serial0;
        bz = (sel != 0) ? busy1   : busy0;
        bd = (sel != 0) ? done1   : done0;
        rd = (sel != 0) ? rd_en1  : rd_en0;
    endtask

    // Checks ncyc frame cycles, starting from the cycle after the pop cycle.
    task automatic check_frame(input int sel, input logic [7:0] d, input int stop,
                               input int ncyc, input int drop_at);
        logic so, bz, bd, rd;
        int   len;
        len = frame_len(stop);
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            sample(sel, so, bz, bd, rd);
            check_val($sformatf("d%0d %02h c%0d serial", sel, d, c), 32'(so), 32'(exp_level(d, c)));
            check_val($sformatf("d%0d %02h c%0d busy", sel, d, c), 32'(bz), 32'd1);
            check_val($sformatf("d%0d %02h c%0d byte_done", sel, d, c), 32'(bd), 32'(c == len));
            check_val($sformatf("d%0d %02h c%0d rd_en", sel, d, c), 32'(rd), 32'd0);
            if (c == drop_at) tx_en0 = 1'b0;
        end
    endtask

    // One idle cycle: line high, not busy, pop as expected.
    task automatic gap_check(input int sel, input string tag, input logic exp_rd);
        logic so, bz, bd, rd;
        @(negedge clk);
        sample(sel, so, bz, bd, rd);
        check_val({tag, " serial"}, 32'(so), 32'd1);
        check_val({tag, " busy"}, 32'(bz), 32'd0);
        check_val({tag, " byte_done"}, 32'(bd), 32'd0);
        check_val({tag, " rd_en"}, 32'(rd), 32'(exp_rd));
    endtask

    // ---- stimulus ----
    initial begin
        int p1;
        int pops_snap;
        reset_n = 1'b0;
        tx_en0  = 1'b1;
        tx_en1  = 1'b1;

        // Reset with data waiting: no pop, line high.
        push0(8'hA5);
        push0(8'h07);
        repeat (3) @(negedge clk);
        check_val("rst serial", 32'(serial0), 32'd1);
        check_val("rst busy", 32'(busy0), 32'd0);
        check_val("rst byte_done", 32'(done0), 32'd0);
        check_val("rst rd_en", 32'(rd_en0), 32'd0);
        check_val("rst pops", 32'(pops0), 32'd0);
        check_val("rst serial1", 32'(serial1), 32'd1);

        // 0xA5 then 0x07 back to back.
        reset_n = 1'b1;
        #1;
        check_val("a5 pop", 32'(rd_en0), 32'd1);
        check_frame(0, 8'hA5, 1, frame_len(1), 0);
        gap_check(0, "gap a5-07", 1'b1);
        check_frame(0, 8'h07, 1, frame_len(1), 0);
        gap_check(0, "after 07", 1'b0);
        check_val("pops after 07", 32'(pops0), 32'd2);

        // Empty FIFO while enabled: stays idle.
        for (int i = 0; i < 5; i++) gap_check(0, "empty idle", 1'b0);

        // 0x00 then 0xFF: pops 41 cycles apart with one idle cycle between.
        push0(8'h00);
        push0(8'hFF);
        #1;
        check_val("00 pop", 32'(rd_en0), 32'd1);
        check_frame(0, 8'h00, 1, frame_len(1), 0);
        p1 = pop_cyc0;
        gap_check(0, "gap 00-ff", 1'b1);
        check_frame(0, 8'hFF, 1, frame_len(1), 0);
        check_val("pop spacing", 32'(pop_cyc0 - p1), 32'(frame_len(1) + 1));

        // tx_enable dropped at cycle 10: frame finishes, no further pop.
        gap_check(0, "after ff", 1'b0);
        push0(8'h5A);
        push0(8'h3C);
        #1;
        check_val("5a pop", 32'(rd_en0), 32'd1);
        check_frame(0, 8'h5A, 1, frame_len(1), 10);
        pops_snap = pops0;
        for (int i = 0; i < 8; i++) gap_check(0, "disabled idle", 1'b0);
        check_val("no pop when disabled", 32'(pops0), 32'(pops_snap));
        wr0    = rdi0;
        tx_en0 = 1'b1;

        // Reset for one cycle during DATA bit 3, then a fresh frame.
        push0(8'hC3);
        push0(8'h81);
        #1;
        check_val("c3 pop", 32'(rd_en0), 32'd1);
        check_frame(0, 8'hC3, 1, 18, 0);
        reset_n = 1'b0;
        pops_snap = pops0;
        @(negedge clk);
        check_val("abort serial", 32'(serial0), 32'd1);
        check_val("abort busy", 32'(busy0), 32'd0);
        check_val("abort rd_en", 32'(rd_en0), 32'd0);
        check_val("abort no pop", 32'(pops0), 32'(pops_snap));
        reset_n = 1'b1;
        #1;
        check_val("81 pop", 32'(rd_en0), 32'd1);
        check_frame(0, 8'h81, 1, frame_len(1), 0);
        gap_check(0, "after 81", 1'b0);

        // Two stop bits on the second instance.
        push1(8'h3C);
        #1;
        check_val("3c pop", 32'(rd_en1), 32'd1);
        check_frame(1, 8'h3C, 2, frame_len(2), 0);
        gap_check(1, "after 3c", 1'b0);
        check_val("pops1", 32'(pops1), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Absolute time bound.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
